// File: rtl/byte_serializer_ctrl.sv
// Word-to-byte serializer controller: accepts a 32-bit word plus byte count and emits bytes over valid/ready.
// Optional BYTE_SER_MSB_FIRST_EN reverses byte order (index starts at len and counts down).
module byte_serializer_ctrl #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [1:0]  byte_idx,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       len_q, len_d;
    logic [1:0]       idx_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [1:0]       start_idx;
    logic [1:0]       next_idx;
    logic             last_nxt;

    // Byte ordering: where the index starts, how it steps, and which index ends the word
`ifdef BYTE_SER_MSB_FIRST_EN
    assign start_idx = in_len;
    assign next_idx  = 2'(byte_idx - 2'd1);
    assign last_nxt  = (state_d == S_SEND) && (idx_d == 2'd0);
`else
    assign start_idx = 2'd0;
    assign next_idx  = 2'(byte_idx + 2'd1);
    assign last_nxt  = (state_d == S_SEND) && (idx_d == len_d);
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        idx_d   = byte_idx;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    len_d   = in_len;
                    idx_d   = start_idx;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = next_idx;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = CNT_W'(GAP_CYCLES - 1);
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = CNT_W'(gap_q - 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registers; every output is derived from the next-state values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
            byte_idx  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_SEND);
            out_byte  <= word_d[{idx_d, 3'b000} +: 8];
            out_last  <= last_nxt;
            byte_idx  <= idx_d;
            busy      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_byte_serializer_ctrl.sv
// Self-checking bench for byte_serializer_ctrl: vector table, scoreboard queue and multi-cycle corner sequences.
module tb_byte_serializer_ctrl;

    localparam int unsigned MAXW = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        out_valid, out_ready, out_last, busy;
    logic [7:0]  out_byte;
    logic [1:0]  byte_idx;

    logic        g_in_valid, g_in_ready;
    logic [31:0] g_in_data;
    logic [1:0]  g_in_len;
    logic        g_out_valid, g_out_ready, g_out_last, g_busy;
    logic [7:0]  g_out_byte;
    logic [1:0]  g_byte_idx;

    always #5 clk = ~clk;

    byte_serializer_ctrl #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .byte_idx(byte_idx), .busy(busy)
    );

    byte_serializer_ctrl #(.GAP_CYCLES(2)) dut_gap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(g_in_valid), .in_ready(g_in_ready), .in_data(g_in_data), .in_len(g_in_len),
        .out_valid(g_out_valid), .out_ready(g_out_ready), .out_byte(g_out_byte),
        .out_last(g_out_last), .byte_idx(g_byte_idx), .busy(g_busy)
    );

    typedef struct {
        logic [7:0] b;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    typedef struct {
        logic [31:0]      data;
        logic [1:0]       len;
        logic [3:0][7:0]  ex;   // expected byte per index, written by hand
    } vec_t;

    exp_t q[$];
    vec_t vecs[4];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard pop on every byte handshake of the GAP_CYCLES=0 instance
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual %0h required none", out_byte);
            end else begin
                e = q.pop_front();
                chk("sb_out_byte", 32'(out_byte), 32'(e.b));
                chk("sb_byte_idx", 32'(byte_idx), 32'(e.idx));
                chk("sb_out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic push_word(input logic [1:0] len, input logic [3:0][7:0] ex);
        for (int k = 0; k <= int'(len); k++) begin
            exp_t e;
`ifdef BYTE_SER_MSB_FIRST_EN
            e.idx = 2'(int'(len) - k);
`else
            e.idx = 2'(k);
`endif
            e.b    = ex[e.idx];
            e.last = (k == int'(len));
            q.push_back(e);
        end
    endtask

    // Offer one word; returns at #1 after the accepting edge
    task automatic accept(input logic [31:0] d, input logic [1:0] len, input logic [3:0][7:0] ex);
        int n = 0;
        while (!in_ready && n < int'(MAXW)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        push_word(len, ex);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_len   = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < int'(MAXW)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    // One byte per cycle, then IDLE with in_ready right after the last handshake
    task automatic stream_check(input logic [1:0] len);
        for (int k = 0; k <= int'(len); k++) begin
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("stream_in_ready_after_last", 32'(in_ready), 32'd1);
        chk("stream_out_valid_after_last", 32'(out_valid), 32'd0);
        chk("stream_busy_after_last", 32'(busy), 32'd0);
        chk("stream_queue_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_byte"}, 32'(out_byte), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_byte_idx"}, 32'(byte_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]      gpat;
        logic [7:0]      gb[3];
        logic [3:0][7:0] ex_a;

        vecs[0] = '{32'hA1B2C3D4, 2'd3, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
        vecs[1] = '{32'h00001234, 2'd1, {8'h00, 8'h00, 8'h12, 8'h34}};
        vecs[2] = '{32'hDEADBEEF, 2'd0, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[3] = '{32'h11223344, 2'd2, {8'h11, 8'h22, 8'h33, 8'h44}};
        ex_a = {8'hA1, 8'hB2, 8'hC3, 8'hD4};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_len      = '0;
        out_ready   = 1'b0;
        g_in_valid  = 1'b0;
        g_in_data   = '0;
        g_in_len    = '0;
        g_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
        chk("gap_in_ready_after_release", 32'(g_in_ready), 32'd1);

        // Back-to-back words from the vector table, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            accept(vecs[i].data, vecs[i].len, vecs[i].ex);
            stream_check(vecs[i].len);
        end

        // Backpressure on the second presented byte
        accept(32'hA1B2C3D4, 2'd3, ex_a);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_byte", 32'(out_byte), 32'(q[0].b));
            chk("stall_byte_idx", 32'(byte_idx), 32'(q[0].idx));
            chk("stall_out_last", 32'(out_last), 32'(q[0].last));
            chk("stall_queue_size", 32'(q.size()), 32'd3);
        end
        out_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        chk("stall_in_ready_after", 32'(in_ready), 32'd1);

        // GAP_CYCLES=2 instance: valid pattern and byte order
`ifdef BYTE_SER_MSB_FIRST_EN
        gb[0] = 8'hB2; gb[1] = 8'hC3; gb[2] = 8'hD4;
`else
        gb[0] = 8'hD4; gb[1] = 8'hC3; gb[2] = 8'hB2;
`endif
        gpat = 7'b1001001;
        chk("gap_in_ready_before", 32'(g_in_ready), 32'd1);
        g_in_valid = 1'b1;
        g_in_data  = 32'hA1B2C3D4;
        g_in_len   = 2'd2;
        @(posedge clk); #1;
        g_in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            chk("gap_out_valid", 32'(g_out_valid), 32'(gpat[c]));
            chk("gap_busy", 32'(g_busy), 32'd1);
            if (gpat[c]) begin
                chk("gap_out_byte", 32'(g_out_byte), 32'(gb[c / 3]));
                chk("gap_out_last", 32'(g_out_last), (c == 6) ? 32'd1 : 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("gap_in_ready_after", 32'(g_in_ready), 32'd1);
        chk("gap_busy_after", 32'(g_busy), 32'd0);

        // Reset pulse mid-word abandons the word
        accept(32'hA1B2C3D4, 2'd3, ex_a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_consumed", 32'(q.size()), 32'd2);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1;
        check_reset_outputs("midword_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midword_in_ready_after_release", 32'(in_ready), 32'd1);
        chk("midword_out_valid_after_release", 32'(out_valid), 32'd0);
        accept(vecs[3].data, vecs[3].len, vecs[3].ex);
        stream_check(vecs[3].len);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
